cpu_mc: RTL

CPU_MC -- requirements
Module: cpu_mc

---
 rtl/cpu_mc_pkg.sv | 39 +++
 rtl/cpu_mc_regfile.sv | 36 +++
 rtl/cpu_mc.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/cpu_mc_pkg.sv
// cpu_mc_pkg: shared definitions for the multi-cycle CPU.
//   - opcode constants
//   - FSM state enum
//   - instruction field positions/widths
package cpu_mc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_LI   = 4'h6;
  localparam logic [3:0] OP_LD   = 4'h7;
  localparam logic [3:0] OP_ST   = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_JZ   = 4'hA;
  localparam logic [3:0] OP_JNZ  = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Instruction word: [31:28] op, [27:24] rd, [23:20] ra, [19:16] rb, [15:0] imm
  localparam int OP_LSB  = 28;
  localparam int RD_LSB  = 24;
  localparam int RA_LSB  = 20;
  localparam int RB_LSB  = 16;
  localparam int IMM_LSB = 0;
  localparam int FLD_W   = 4;
  localparam int IMM_W   = 16;

endpackage

// File: rtl/cpu_mc_regfile.sv
// cpu_mc_regfile: NREG x DATA_W register file.
//   clk, rst_n          clock, async active-low reset (clears every register)
//   we, waddr, wdata    single write port
//   ra_addr/ra_data     combinational read port A
//   rb_addr/rb_data     combinational read port B
//   dbg_addr/dbg_data   combinational debug read port
module cpu_mc_regfile #(
  parameter  int DATA_W = 24,
  parameter  int NREG   = 16,
  localparam int RW     = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [RW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [RW-1:0]     ra_addr,
  output logic [DATA_W-1:0] ra_data,
  input  logic [RW-1:0]     rb_addr,
  output logic [DATA_W-1:0] rb_data,
  input  logic [RW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [NREG-1:0][DATA_W-1:0] regs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  regs        <= '0;
    else if (we) regs[waddr] <= wdata;
  end

  assign ra_data  = regs[ra_addr];
  assign rb_data  = regs[rb_addr];
  assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/cpu_mc.sv
// cpu_mc: multi-cycle CPU (IDLE -> FETCH -> EXEC -> [MEM] -> [WB] -> FETCH).
//   clk, rst_n                 clock, async active-low reset
//   imem_req/addr/ack/data     instruction fetch handshake (addr == pc)
//   dmem_req/we/addr/wdata     data access, held stable until dmem_ack
//   dmem_ack/rdata             data completion, rdata valid with ack
//   dbg_addr/dbg_data          combinational register peek
//   pc, halted                 program counter, HALT state flag
// NREG must be a power of two in 4..16; register fields use its low bits.
module cpu_mc
  import cpu_mc_pkg::*;
#(
  parameter  int DATA_W = 24,
  parameter  int NREG   = 16,
  parameter  int PC_W   = 8,
  localparam int RW     = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_data,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic [RW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [PC_W-1:0]   pc,
  output logic              halted
);

  state_t            state;
  logic [31:0]       ir;
  logic              zf;
  logic [DATA_W-1:0] wb_data;

  logic [FLD_W-1:0]  op;
  logic [RW-1:0]     rd, ra, rb;
  logic [IMM_W-1:0]  imm;
  logic [DATA_W-1:0] ra_data, rb_data, alu_y;
  logic [PC_W-1:0]   pc_inc;
  logic              taken;

  assign op  = ir[OP_LSB  +: FLD_W];
  assign rd  = ir[RD_LSB  +: RW];
  assign ra  = ir[RA_LSB  +: RW];
  assign rb  = ir[RB_LSB  +: RW];
  assign imm = ir[IMM_LSB +: IMM_W];

  assign imem_addr = pc;
  assign pc_inc    = pc + PC_W'(1);

  // Writes happen only in WB; the value was staged in wb_data by EXEC or MEM,
  // so dbg_data shows the old value during WB and the new one afterwards.
  cpu_mc_regfile #(.DATA_W(DATA_W), .NREG(NREG)) u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (state == S_WB),
    .waddr    (rd),
    .wdata    (wb_data),
    .ra_addr  (ra),
    .ra_data  (ra_data),
    .rb_addr  (rb),
    .rb_data  (rb_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always_comb begin
    alu_y = '0;
    case (op)
      OP_ADD:  alu_y = ra_data + rb_data;
      OP_SUB:  alu_y = ra_data - rb_data;
      OP_AND:  alu_y = ra_data & rb_data;
      OP_OR:   alu_y = ra_data | rb_data;
      OP_XOR:  alu_y = ra_data ^ rb_data;
      default: alu_y = '0;
    endcase
  end

  assign taken = (op == OP_JMP) || (op == OP_JZ && zf) || (op == OP_JNZ && !zf);

  // Request outputs are registered and only ever high in their own state, so
  // an ack seen outside FETCH/MEM has no effect, and async reset drops them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pc         <= '0;
      ir         <= '0;
      zf         <= 1'b0;
      wb_data    <= '0;
      imem_req   <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      halted     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state    <= S_FETCH;
          imem_req <= 1'b1;
        end
        S_FETCH: if (imem_ack) begin
          ir       <= imem_data;
          imem_req <= 1'b0;
          state    <= S_EXEC;
        end
        S_EXEC: begin
          case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
              wb_data <= alu_y;
              zf      <= (alu_y == '0);
              state   <= S_WB;
            end
            OP_LI: begin
              wb_data <= DATA_W'(imm);
              state   <= S_WB;
            end
            OP_LD, OP_ST: begin
              // Address captured here, so LD rd==rb uses the pre-write rb.
              dmem_req   <= 1'b1;
              dmem_we    <= (op == OP_ST);
              dmem_addr  <= rb_data;
              dmem_wdata <= ra_data;
              state      <= S_MEM;
            end
            OP_JMP, OP_JZ, OP_JNZ: begin
              pc       <= taken ? PC_W'(imm) : pc_inc;
              imem_req <= 1'b1;
              state    <= S_FETCH;
            end
            OP_HALT: begin
              halted <= 1'b1;
              state  <= S_HALT;
            end
            default: begin
              pc       <= pc_inc;
              imem_req <= 1'b1;
              state    <= S_FETCH;
            end
          endcase
        end
        S_MEM: if (dmem_ack) begin
          dmem_req <= 1'b0;
          dmem_we  <= 1'b0;
          if (dmem_we) begin
            pc       <= pc_inc;
            imem_req <= 1'b1;
            state    <= S_FETCH;
          end else begin
            wb_data <= dmem_rdata;
            state   <= S_WB;
          end
        end
        S_WB: begin
          pc       <= pc_inc;
          imem_req <= 1'b1;
          state    <= S_FETCH;
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
